// File: rtl/wb_commit_queue_pkg.sv
// Shared widths, polarity constants and a slot-availability helper
// for the register-file write-back commit queue.
package wb_commit_queue_pkg;

    localparam int   REG_ADDR_W   = 5;
    localparam int   REG_DATA_W   = 32;
    localparam logic RST_ENABLE   = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READY        = 1'b1;

    // Room for one push, or two when an older producer competes this cycle.
    function automatic logic has_room(input int free, input logic two);
        return free >= (two ? 2 : 1);
    endfunction

endpackage

// File: rtl/wb_fifo_entry_match.sv
// Compares one lookup address against every valid queue entry; any hit means
// an uncommitted write to that register is still in flight.
module wb_fifo_entry_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic [DEPTH-1:0]             vld_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0]            q_addr_i,
    output logic                         match_o
);

    logic [DEPTH-1:0] hit;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        assign hit[g] = vld_i[g] & (addr_i[g] == q_addr_i);
    end

    // Register 0 is hardwired, so it never carries a hazard.
    assign match_o = (|hit) & (q_addr_i != '0);

endmodule

// File: rtl/wb_commit_queue.sv
// In-order commit queue merging LSU and ALU results into a single register
// file write port, with RAW-pending lookups for two decode sources.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = REG_ADDR_W,
    parameter  int DATA_W = REG_DATA_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rdy_i,
    input  logic              flush_i,
    input  logic              lsu_valid_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    output logic              lsu_ready_o,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_addr_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic [ADDR_W-1:0] q1_addr_i,
    output logic              q1_pending_o,
    input  logic [ADDR_W-1:0] q2_addr_i,
    output logic              q2_pending_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PTR_W-1:0]             head_q, tail_q, alu_slot;
    logic [CNT_W-1:0]             count_q;
    logic                         in_rst, active, lsu_push, alu_push, q1_hit, q2_hit;
    int                           free;

    assign in_rst = (rst_ni == RST_ENABLE);
    assign active = ~in_rst & (rdy_i == READY) & ~flush_i;

    // Readiness uses occupancy at cycle start; a same-cycle pop is not credited.
    assign free        = DEPTH - int'(count_q);
    assign lsu_ready_o = active & has_room(free, 1'b0);
    assign alu_ready_o = active & has_room(free, lsu_valid_i);

    assign we_o    = active & (count_q != '0);
    assign waddr_o = we_o ? addr_q[head_q] : '0;
    assign wdata_o = we_o ? data_q[head_q] : '0;
    assign count_o = count_q;

    // Address-0 results handshake normally but are dropped instead of stored.
    assign lsu_push = lsu_valid_i & lsu_ready_o & (lsu_addr_i != '0);
    assign alu_push = alu_valid_i & alu_ready_o & (alu_addr_i != '0);
    assign alu_slot = tail_q + PTR_W'(lsu_push);

    always_comb begin
        vld_d = vld_q;
        if (we_o)     vld_d[head_q]   = 1'b0;
        if (lsu_push) vld_d[tail_q]   = 1'b1;
        if (alu_push) vld_d[alu_slot] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (in_rst || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (we_o) head_q <= head_q + PTR_W'(1);
            tail_q  <= tail_q + PTR_W'(lsu_push) + PTR_W'(alu_push);
            count_q <= count_q + CNT_W'(lsu_push) + CNT_W'(alu_push) - CNT_W'(we_o);
            vld_q   <= vld_d;
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk_i) begin
        if (lsu_push) begin
            addr_q[tail_q] <= lsu_addr_i;
            data_q[tail_q] <= lsu_data_i;
        end
        if (alu_push) begin
            addr_q[alu_slot] <= alu_addr_i;
            data_q[alu_slot] <= alu_data_i;
        end
    end

    wb_fifo_entry_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match1 (
        .vld_i    (vld_q),
        .addr_i   (addr_q),
        .q_addr_i (q1_addr_i),
        .match_o  (q1_hit)
    );

    wb_fifo_entry_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match2 (
        .vld_i    (vld_q),
        .addr_i   (addr_q),
        .q_addr_i (q2_addr_i),
        .match_o  (q2_hit)
    );

    assign q1_pending_o = ~in_rst & q1_hit;
    assign q2_pending_o = ~in_rst & q2_hit;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Randomized bench for wb_commit_queue against a queue-based reference model.
module tb_wb_commit_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush;
    logic        lsu_valid, alu_valid, lsu_ready, alu_ready;
    logic [4:0]  lsu_addr, alu_addr, waddr, q1_addr, q2_addr;
    logic [31:0] lsu_data, alu_data, wdata;
    logic        we, q1_pending, q2_pending;
    logic [2:0]  count;

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    wb_commit_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rdy_i        (rdy),
        .flush_i      (flush),
        .lsu_valid_i  (lsu_valid),
        .lsu_addr_i   (lsu_addr),
        .lsu_data_i   (lsu_data),
        .lsu_ready_o  (lsu_ready),
        .alu_valid_i  (alu_valid),
        .alu_addr_i   (alu_addr),
        .alu_data_i   (alu_data),
        .alu_ready_o  (alu_ready),
        .we_o         (we),
        .waddr_o      (waddr),
        .wdata_o      (wdata),
        .q1_addr_i    (q1_addr),
        .q1_pending_o (q1_pending),
        .q2_addr_i    (q2_addr),
        .q2_pending_o (q2_pending),
        .count_o      (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_pending(input logic [4:0] qa);
        if (qa == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == qa) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at the falling edge, check outputs, advance the model.
    task automatic step(input logic r, input logic rd, input logic fl,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic [4:0] qa1, input logic [4:0] qa2);
        logic run, e_lr, e_ar, e_we;
        int   free;
        rst_n = r; rdy = rd; flush = fl;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        q1_addr = qa1; q2_addr = qa2;
        #1;
        run  = r && rd && !fl;
        free = DEPTH - mq.size();
        e_lr = run && (free >= 1);
        e_ar = run && (free >= (lv ? 2 : 1));
        e_we = run && (mq.size() > 0);
        chk("count",     64'(count),     64'(mq.size()));
        chk("lsu_ready", 64'(lsu_ready), 64'(e_lr));
        chk("alu_ready", 64'(alu_ready), 64'(e_ar));
        chk("we",        64'(we),        64'(e_we));
        chk("waddr",     64'(waddr),     e_we ? 64'(mq[0].a) : 64'd0);
        chk("wdata",     64'(wdata),     e_we ? 64'(mq[0].d) : 64'd0);
        chk("q1_pending", 64'(q1_pending), 64'(r && model_pending(qa1)));
        chk("q2_pending", 64'(q2_pending), 64'(r && model_pending(qa2)));
        if (!r || fl) begin
            mq.delete();
        end else if (rd) begin
            if (e_we) void'(mq.pop_front());
            if (lv && e_lr && la != 5'd0) mq.push_back('{a: la, d: ld});
            if (av && e_ar && aa != 5'd0) mq.push_back('{a: aa, d: ad});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] qa1);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, qa1, 0);
    endtask

    initial begin
        rst_n = 0; rdy = 0; flush = 0;
        lsu_valid = 0; lsu_addr = 0; lsu_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        q1_addr = 0; q2_addr = 0;
        @(posedge clk);
        @(negedge clk);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // single LSU push, one-cycle latency to the write
        step(1, 1, 0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 5'd3, 0);
        idle(2, 5'd3);

        // dual push to the same register: LSU retires first
        step(1, 1, 0, 1, 5'd5, 32'h11, 1, 5'd5, 32'h22, 5'd5, 0);
        idle(3, 5'd5);

        // backpressure: keep both producers busy until occupancy saturates
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 1, 5'(i + 1), $urandom, 1, 5'(i + 9), $urandom, 5'(i + 1), 5'(i + 9));
        idle(4, 0);

        // address-0 push is accepted but never stored
        step(1, 1, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
        idle(2, 0);

        // rdy stall with two entries queued
        step(1, 1, 0, 1, 5'd7, 32'hA7, 1, 5'd8, 32'hA8, 5'd7, 5'd8);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 5'd9, 32'h9, 1, 5'd10, 32'h10, 5'd7, 5'd8);
        idle(3, 5'd8);

        // flush, then reset, with three entries queued
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 0);
            step(1, 1, 0, 1, 5'd3, 32'h3, 1, 5'd4, 32'h4, 0, 0);
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
            if (k == 0) step(1, 1, 1, 1, 5'd6, 32'h6, 1, 5'd6, 32'h6, 5'd3, 5'd4);
            else        step(0, 1, 0, 1, 5'd6, 32'h6, 1, 5'd6, 32'h6, 5'd3, 5'd4);
            idle(2, 5'd3);
        end

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Writer-side front end for the CPU register file write port (we/waddr/wdata).
- Collects results from two producers, the ALU and the load/store unit, into a small in-order FIFO and retires at most one register write per cycle.
- Also answers "write pending?" lookups for two decode-stage source addresses, so issue logic can stall on RAW hazards against uncommitted results.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- ADDR_W, 5, register address width (`RegNumLog2`).
- DATA_W, 32, register data width (`RegBus`).

Ports:
- clk  in  1  system clock.
- rst  in  1  one clock; reset is synchronous and active-low.
- rdy  in  1  global ready; 0 freezes the block (no push, no pop).
- flush  in  1  squash all queued, uncommitted results.
- lsu_valid  in  1  load result offered.
- lsu_addr  in  ADDR_W  load destination register.
- lsu_data  in  DATA_W  load result.
- lsu_ready  out  1  load result accepted this cycle when lsu_valid=1.
- alu_valid  in  1  ALU result offered.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1.
- we  out  1  register file write enable.
- waddr  out  ADDR_W  register file write address.
- wdata  out  DATA_W  register file write data.
- q1_addr  in  ADDR_W  lookup address 1.
- q1_pending  out  1  a queued entry targets q1_addr.
- q2_addr  in  ADDR_W  lookup address 2.
- q2_pending  out  1  a queued entry targets q2_addr.
- count  out  clog2(DEPTH+1)  occupied entries.

Behaviour:
- Storage:
  - Circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - count register tracks occupancy; empty = (count==0).
- Reset (rst==0 at posedge):
  - head=tail=count=0; all entry valid bits cleared.
  - Outputs settle to we=0, waddr=0, wdata=0, pending=0, readys=0.
  - A reset mid-operation discards all queued entries; nothing is written to the register file.
- Pop (combinational outputs from head):
  - we = rdy & ~flush & ~empty; waddr/wdata = head entry, else 0.
  - When we=1 the head advances at the posedge, so each entry produces exactly one write.
- Push readiness:
  - Uses the free-slot count at cycle start: free = DEPTH - count. A same-cycle pop is not credited, so there is no combinational path rdy→ready through pop.
  - lsu_ready = rdy & ~flush & (free ≥ 1).
  - alu_ready = rdy & ~flush & (free ≥ (lsu_valid ? 2 : 1)).
- Push ordering:
  - Both producers may push in the same cycle; the LSU entry is enqueued first (it is the older instruction), then the ALU entry.
- Address 0:
  - A handshake with addr==0 is accepted but not stored and consumes no slot; readiness is still computed as above.
- count update: count_next = count + pushes_stored - pop.
  - Simultaneous push and pop when full is impossible by construction.
  - Push into empty: we=1 in the following cycle (1-cycle latency).
- Pending lookups:
  - qN_pending = (qN_addr != 0) & OR over valid entries of (entry.addr == qN_addr).
  - Purely combinational; the current-cycle head still counts as pending.
  - Pushes in the current cycle are not visible until the next cycle.
- Flush:
  - Forces we=0 and both readys to 0 in the flush cycle.
  - At the posedge: head=tail=count=0 and all valid bits cleared.
  - Flush has priority over rdy.
- rdy=0: state holds; we=0, readys=0; pending outputs stay live.
- Ordering guarantee: writes to the same register retire in enqueue order.

Decomposition:
- Shared defines: ADDR_W/DATA_W from `RegAddrBus`/`RegBus`, `RstEnable`-style polarity macro for active-low reset, `WriteEnable`, `Ready`.
- One natural sub-module: wb_fifo_entry_match, the per-entry valid+address comparator array used for q1/q2 pending, instantiated twice.

Test Plan:
- Reset then single push: lsu_valid=1, addr=3, data=0xDEADBEEF at cycle 1 → lsu_ready=1; cycle 2 we=1, waddr=3, wdata=0xDEADBEEF; cycle 3 we=0, count=0.
- Dual push: lsu (5,0x11) and alu (5,0x22) in one cycle with empty queue → count=2; writes retire (5,0x11) then (5,0x22); q1_addr=5 gives pending=1 until after the second write.
- Full/backpressure: fill 4 entries with rdy=1 and no pops possible in the fill cycle → count=4, both readys=0; with lsu_valid=1 and count=3 → alu_ready=0, lsu_ready=1.
- Addr zero: alu push addr=0, data=0xFFFF → alu_ready=1, count stays 0, we never asserted, q1_addr=0 gives pending=0.
- rdy stall: with 2 entries queued, hold rdy=0 for 3 cycles → we=0, count=2 constant; rdy=1 → two consecutive writes.
- Flush and reset mid-stream: 3 entries queued, flush=1 → we=0 that cycle, count=0 next, pendings 0; repeat with rst=0 instead → identical empty state, no register write issued.
